// File: rtl/vfpm_seq_ctrl.sv
// Issue/collect sequencer for the vector FP multiply: walks element indices into the
// operand bank, writes multiplier results into the C bank in order, and tracks status.
module vfpm_seq_ctrl #(
   parameter int VLEN = 32,
   parameter int AW   = 5,
   parameter int LAT  = 2,
   parameter int TMO  = 4
) (
   input  logic          Clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic          hold,
   input  logic          mul_valid_out,
   input  logic          mul_flag,
   output logic          busy,
   output logic          done,
   output logic          full,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          op_valid,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic          flag_or,
   output logic [AW:0]   flag_cnt,
   output logic          err_timeout,
   output logic          err_spurious
);

   localparam int DW = $clog2(LAT + TMO + 1);
   localparam logic [AW:0]   VLEN_C     = (AW+1)'(VLEN);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT + TMO - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [AW:0]   n_q, n_d;
   logic [AW:0]   issue_cnt_q, issue_cnt_d;
   logic [AW:0]   wr_cnt_q, wr_cnt_d;
   logic [AW:0]   flag_cnt_q, flag_cnt_d;
   logic [DW-1:0] drain_cnt_q, drain_cnt_d;
   logic          flag_or_q, flag_or_d;
   logic          full_q, full_d;
   logic          err_timeout_q, err_timeout_d;
   logic          err_spurious_q, err_spurious_d;
   logic          op_valid_q;
   logic          last_wr;

   function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
      if (l == '0 || l > VLEN_C) return VLEN_C;
      return l;
   endfunction

   function automatic logic [AW:0] sat_inc(input logic [AW:0] c, input logic inc);
      if (inc && c < VLEN_C) return c + 1'b1;
      return c;
   endfunction

   assign busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign last_wr = (wr_cnt_q == n_q - 1'b1);

   always_comb begin
      state_d        = state_q;
      n_d            = n_q;
      issue_cnt_d    = issue_cnt_q;
      wr_cnt_d       = wr_cnt_q;
      drain_cnt_d    = drain_cnt_q;
      flag_or_d      = flag_or_q;
      flag_cnt_d     = flag_cnt_q;
      full_d         = full_q;
      err_timeout_d  = err_timeout_q;
      err_spurious_d = err_spurious_q;
      rd_en          = 1'b0;
      wr_en          = 1'b0;
      done           = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d            = clamp_len(len);
               issue_cnt_d    = '0;
               wr_cnt_d       = '0;
               flag_or_d      = 1'b0;
               flag_cnt_d     = '0;
               full_d         = 1'b0;
               err_timeout_d  = 1'b0;
               err_spurious_d = 1'b0;
               state_d        = S_ISSUE;
            end
            if (mul_valid_out) err_spurious_d = 1'b1;
         end
         S_ISSUE: begin
            rd_en = !hold;
            if (rd_en) begin
               issue_cnt_d = issue_cnt_q + 1'b1;
               if (issue_cnt_q == n_q - 1'b1) begin
                  state_d     = S_DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q + 1'b1;
            // a final write landing on the last allowed cycle still counts as on time
            if (drain_cnt_q == DRAIN_LAST && !(mul_valid_out && last_wr)) begin
               err_timeout_d = 1'b1;
               state_d       = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            full_d  = 1'b1;
            state_d = S_IDLE;
            if (mul_valid_out) err_spurious_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // results overlap issue, so the write side runs in both ISSUE and DRAIN
      if (busy && mul_valid_out) begin
         wr_en      = 1'b1;
         wr_cnt_d   = wr_cnt_q + 1'b1;
         flag_or_d  = flag_or_q | mul_flag;
         flag_cnt_d = sat_inc(flag_cnt_q, mul_flag);
         if (last_wr) state_d = S_DONE;
      end
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         n_q            <= '0;
         issue_cnt_q    <= '0;
         wr_cnt_q       <= '0;
         drain_cnt_q    <= '0;
         flag_or_q      <= 1'b0;
         flag_cnt_q     <= '0;
         full_q         <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_spurious_q <= 1'b0;
         op_valid_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         n_q            <= n_d;
         issue_cnt_q    <= issue_cnt_d;
         wr_cnt_q       <= wr_cnt_d;
         drain_cnt_q    <= drain_cnt_d;
         flag_or_q      <= flag_or_d;
         flag_cnt_q     <= flag_cnt_d;
         full_q         <= full_d;
         err_timeout_q  <= err_timeout_d;
         err_spurious_q <= err_spurious_d;
         op_valid_q     <= rd_en;
      end
   end

   assign full         = full_q;
   assign op_valid     = op_valid_q;
   assign rd_addr      = issue_cnt_q[AW-1:0];
   assign wr_addr      = wr_cnt_q[AW-1:0];
   assign flag_or      = flag_or_q;
   assign flag_cnt     = flag_cnt_q;
   assign err_timeout  = err_timeout_q;
   assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_vfpm_seq_ctrl.sv
// Bench for vfpm_seq_ctrl: directed vector table, reset/spurious sequence and random runs,
// all checked cycle by cycle against a schedule model built from the timing rules.
module tb_vfpm_seq_ctrl;

   localparam int VLEN = 32;
   localparam int AW   = 5;
   localparam int LAT  = 2;
   localparam int TMO  = 4;
   localparam int MAXC = 200;

   logic          Clk, reset, start, hold, mul_valid_out, mul_flag;
   logic [AW:0]   len;
   logic          busy, done, full, rd_en, op_valid, wr_en, flag_or, err_timeout, err_spurious;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [AW:0]   flag_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   vfpm_seq_ctrl #(.VLEN(VLEN), .AW(AW), .LAT(LAT), .TMO(TMO)) dut (
      .Clk(Clk), .reset(reset), .start(start), .len(len), .hold(hold),
      .mul_valid_out(mul_valid_out), .mul_flag(mul_flag), .busy(busy), .done(done),
      .full(full), .rd_en(rd_en), .rd_addr(rd_addr), .op_valid(op_valid), .wr_en(wr_en),
      .wr_addr(wr_addr), .flag_or(flag_or), .flag_cnt(flag_cnt),
      .err_timeout(err_timeout), .err_spurious(err_spurious)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // stimulus schedule and reference expectations, indexed by cycle after start
   bit hold_arr[MAXC];
   bit start_arr[MAXC];
   bit e_rd[MAXC], e_ov[MAXC], e_wr[MAXC], e_busy[MAXC];
   int e_rda[MAXC], e_wra[MAXC];
   int e_D, e_cnt, e_or;

   task automatic build_model(input int len_i, input logic [31:0] fl, input int drop);
      int n, issued, c, last_iss, k, w, last_res;
      for (int i = 0; i < MAXC; i++) begin
         e_rd[i] = 0; e_ov[i] = 0; e_wr[i] = 0; e_busy[i] = 0; e_rda[i] = 0; e_wra[i] = 0;
      end
      n = (len_i == 0 || len_i > VLEN) ? VLEN : len_i;
      issued = 0;
      c = 1;
      while (issued < n) begin
         if (!hold_arr[c]) begin
            e_rd[c]  = 1;
            e_rda[c] = issued;
            issued++;
         end
         c++;
      end
      last_iss = c - 1;
      k = 0; w = 0; last_res = 0; e_cnt = 0; e_or = 0;
      for (int t = 1; t <= last_iss; t++) begin
         if (e_rd[t]) begin
            e_ov[t+1] = 1;
            if (k != drop) begin
               e_wr[t+1+LAT]  = 1;
               e_wra[t+1+LAT] = w;
               w++;
               last_res = t + 1 + LAT;
               e_cnt += int'(fl[k]);
               e_or  |= int'(fl[k]);
            end
            k++;
         end
      end
      e_D = (w == n) ? last_res + 1 : last_iss + 1 + LAT + TMO;
      for (int t = 1; t < e_D; t++) e_busy[t] = 1;
   endtask

   task automatic run_vec(input int len_i, input logic [31:0] fl, input int drop,
                          output int done_cyc);
      int res_idx;
      bit ov_hist[MAXC];
      build_model(len_i, fl, drop);
      done_cyc = -1;
      res_idx  = 0;
      for (int i = 0; i < MAXC; i++) ov_hist[i] = 0;
      start = 1'b1; len = (AW+1)'(len_i); hold = 1'b0; mul_valid_out = 1'b0; mul_flag = 1'b0;
      @(posedge Clk); #1;
      start = 1'b0;
      for (int c = 1; c <= e_D + 2; c++) begin
         hold          = hold_arr[c];
         start         = (c <= e_D) ? start_arr[c] : 1'b0;
         mul_valid_out = 1'b0;
         mul_flag      = 1'($urandom);
         if (c > LAT && ov_hist[c-LAT]) begin
            if (res_idx != drop && res_idx < 32) begin
               mul_valid_out = 1'b1;
               mul_flag      = fl[res_idx];
            end
            res_idx++;
         end
         @(negedge Clk);
         ov_hist[c] = op_valid;
         if (done && done_cyc < 0) done_cyc = c;
         chk($sformatf("rd_en c%0d", c), int'(rd_en), int'(e_rd[c]));
         if (e_rd[c]) chk($sformatf("rd_addr c%0d", c), int'(rd_addr), e_rda[c]);
         chk($sformatf("op_valid c%0d", c), int'(op_valid), int'(e_ov[c]));
         chk($sformatf("wr_en c%0d", c), int'(wr_en), int'(e_wr[c]));
         if (e_wr[c]) chk($sformatf("wr_addr c%0d", c), int'(wr_addr), e_wra[c]);
         chk($sformatf("done c%0d", c), int'(done), int'(c == e_D));
         chk($sformatf("busy c%0d", c), int'(busy), int'(e_busy[c]));
         chk($sformatf("full c%0d", c), int'(full), int'(c > e_D));
         if (c == 1) begin
            chk("cleared flag_cnt", int'(flag_cnt), 0);
            chk("cleared flag_or", int'(flag_or), 0);
            chk("cleared err_timeout", int'(err_timeout), 0);
            chk("cleared err_spurious", int'(err_spurious), 0);
         end
         @(posedge Clk); #1;
      end
      start = 1'b0; hold = 1'b0; mul_valid_out = 1'b0; mul_flag = 1'b0;
   endtask

   typedef struct {
      int          len;
      int          hold_lo;
      int          hold_n;
      logic [31:0] flags;
      int          drop;
      int          st_a;
      int          st_b;
      int          exp_done;
      int          exp_cnt;
      int          exp_or;
      int          exp_to;
   } vec_t;

   vec_t tbl[8];

   task automatic clear_sched();
      for (int i = 0; i < MAXC; i++) begin
         hold_arr[i]  = 0;
         start_arr[i] = 0;
      end
   endtask

   initial begin
      int          dc;
      int          lr;
      logic [31:0] fr;
      logic [24:0] outs;
      bit          found;

      tbl[0] = '{32, 0, 0, 32'h0,        -1, 0, 0,  36, 0,  0, 0};
      tbl[1] = '{5,  3, 3, 32'h0,        -1, 0, 0,  12, 0,  0, 0};
      tbl[2] = '{8,  0, 0, 32'h84,       -1, 0, 0,  12, 2,  1, 0};
      tbl[3] = '{0,  0, 0, 32'h0,        -1, 0, 0,  36, 0,  0, 0};
      tbl[4] = '{40, 0, 0, 32'h0,        -1, 5, 20, 36, 0,  0, 0};
      tbl[5] = '{4,  0, 0, 32'h0A,        3, 0, 0,  11, 1,  1, 1};
      tbl[6] = '{1,  0, 0, 32'h0,        -1, 0, 0,  5,  0,  0, 0};
      tbl[7] = '{32, 0, 0, 32'hFFFFFFFF, -1, 0, 0,  36, 32, 1, 0};

      reset = 1'b1; start = 1'b0; len = '0; hold = 1'b0; mul_valid_out = 1'b0; mul_flag = 1'b0;
      #1 reset = 1'b0;
      #3;
      outs = {busy, done, full, rd_en, rd_addr, op_valid, wr_en, wr_addr,
              flag_or, flag_cnt, err_timeout, err_spurious};
      chk("reset outputs", int'(outs), 0);
      @(posedge Clk); @(posedge Clk); #2 reset = 1'b1;
      @(posedge Clk); #1;

      for (int v = 0; v < 8; v++) begin
         clear_sched();
         for (int h = 0; h < tbl[v].hold_n; h++) hold_arr[tbl[v].hold_lo + h] = 1;
         if (tbl[v].st_a > 0) start_arr[tbl[v].st_a] = 1;
         if (tbl[v].st_b > 0) start_arr[tbl[v].st_b] = 1;
         run_vec(tbl[v].len, tbl[v].flags, tbl[v].drop, dc);
         chk($sformatf("vec%0d done cycle", v), dc, tbl[v].exp_done);
         chk($sformatf("vec%0d flag_cnt", v), int'(flag_cnt), tbl[v].exp_cnt);
         chk($sformatf("vec%0d flag_or", v), int'(flag_or), tbl[v].exp_or);
         chk($sformatf("vec%0d err_timeout", v), int'(err_timeout), tbl[v].exp_to);
         chk($sformatf("vec%0d err_spurious", v), int'(err_spurious), 0);
      end

      // reset in the middle of issue, then a stray result while idle
      start = 1'b1; len = 6'd32;
      @(posedge Clk); #1;
      start = 1'b0;
      found = 0;
      for (int i = 1; i <= 20; i++) begin
         if (rd_en && rd_addr == 5'd10) begin
            found = 1;
            break;
         end
         @(posedge Clk); #1;
      end
      chk("reached element 10", int'(found), 1);
      #2 reset = 1'b0;
      #1;
      outs = {busy, done, full, rd_en, rd_addr, op_valid, wr_en, wr_addr,
              flag_or, flag_cnt, err_timeout, err_spurious};
      chk("mid-issue reset outputs", int'(outs), 0);
      @(posedge Clk); #2 reset = 1'b1;
      mul_valid_out = 1'b1; mul_flag = 1'b1;
      #1;
      chk("idle result wr_en", int'(wr_en), 0);
      @(posedge Clk); #1;
      mul_valid_out = 1'b0; mul_flag = 1'b0;
      chk("idle result err_spurious", int'(err_spurious), 1);
      chk("idle result flag_cnt", int'(flag_cnt), 0);
      chk("idle result busy", int'(busy), 0);
      clear_sched();
      run_vec(3, 32'h0, -1, dc);
      chk("post-reset done cycle", dc, 7);
      chk("post-reset full", int'(full), 1);

      for (int r = 0; r < 16; r++) begin
         clear_sched();
         for (int c = 1; c < 100; c++) begin
            hold_arr[c]  = ($urandom_range(0, 3) == 0);
            start_arr[c] = ($urandom_range(0, 7) == 0);
         end
         lr = $urandom_range(0, 63);
         fr = $urandom;
         run_vec(lr, fr, -1, dc);
         chk($sformatf("rand%0d done cycle", r), dc, e_D);
         chk($sformatf("rand%0d flag_cnt", r), int'(flag_cnt), e_cnt);
         chk($sformatf("rand%0d flag_or", r), int'(flag_or), e_or);
         chk($sformatf("rand%0d err_timeout", r), int'(err_timeout), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vfpm_seq_ctrl.md
Name: vfpm_seq_ctrl

Overview:
Sequencer for the 32-element vector floating-point multiply.
- On `start`, issues element indices to the operand bank (A/B pair per index, synchronous read) and aligns an operand-valid strobe into the pipelined multiplier.
- Collects multiplier results into the C bank in order and accumulates per-vector exception status.
- Signals completion with a `done` pulse and a `full` level.
- Sits between the top-level command interface and the multiplier/register-bank datapath.

Parameters:
- VLEN, 32, maximum vector length (elements per A/B/C bank).
- AW, 5, element address width, clog2(VLEN).
- LAT, 2, multiplier latency in cycles from `op_valid` to `mul_valid_out`.
- TMO, 4, extra drain cycles tolerated beyond LAT before timeout.

Ports:
- Clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin vector operation; sampled only in IDLE.
- len  in  AW+1  element count; 0 means VLEN; values above VLEN clamp to VLEN.
- hold  in  1  pauses issue while high; the in-flight pipeline keeps draining.
- mul_valid_out  in  1  multiplier result valid.
- mul_flag  in  1  exception flag for the current result; qualified by `mul_valid_out`.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle completion pulse.
- full  out  1  C bank holds a complete result; cleared by the next accepted start.
- rd_en  out  1  operand bank read enable.
- rd_addr  out  AW  operand element index.
- op_valid  out  1  `rd_en` delayed by one cycle; aligned with read data into the multiplier.
- wr_en  out  1  C bank write enable.
- wr_addr  out  AW  C bank element index.
- flag_or  out  1  sticky OR of `mul_flag` over the vector.
- flag_cnt  out  AW+1  count of flagged elements.
- err_timeout  out  1  sticky; drain exceeded LAT+TMO cycles.
- err_spurious  out  1  sticky; `mul_valid_out` seen in IDLE or after the last write.

Behaviour:
Reset (async, active-low) and power-up:
- State goes to IDLE.
- All outputs and counters are 0; this includes `full`, `flag_cnt` and both error flags.
- Reset mid-operation abandons the vector; any late multiplier results are ignored.

States: IDLE, ISSUE, DRAIN, DONE.

IDLE:
- `start` latches `n = (len==0 || len>VLEN) ? VLEN : len`.
- Clears issue_cnt, wr_cnt, flag_or, flag_cnt, both error flags and `full`.
- Transitions to ISSUE.

ISSUE:
- `rd_en = !hold` (combinational); `rd_addr = issue_cnt`.
- issue_cnt increments on each issued index.
- After issuing index n-1 (i.e. issuing while issue_cnt == n-1), transition to DRAIN.

DRAIN:
- Waits for the last write.
- A drain counter counts cycles in DRAIN. If it reaches LAT+TMO before the final write: set `err_timeout` and go to DONE.

DONE (one cycle):
- `done = 1` and `full <= 1`; return to IDLE.

Write side (active in ISSUE and DRAIN):
- `wr_en = mul_valid_out`; `wr_addr = wr_cnt`.
- On each write: wr_cnt increments; `flag_or |= mul_flag`; `flag_cnt += mul_flag`.
- The write with wr_cnt == n-1 moves the FSM to DONE on the next edge.
- Writes in ISSUE and DRAIN are both accepted (the pipeline overlaps issue).
- `mul_valid_out` in IDLE or DONE: `wr_en` stays 0 and `err_spurious` is set.

Other rules:
- `op_valid` is a register: `op_valid <= rd_en`.
- `start` while busy or in DONE is ignored; no effect on any state.
- `hold` outside ISSUE has no effect.
- Counters never wrap within a vector; `flag_cnt` maxes at VLEN.

Latency, with start sampled at edge 0, no hold:
- `rd_en` high cycles 1..n.
- `op_valid` high cycles 2..n+1.
- Results in cycles 2+LAT..n+1+LAT.
- `done` in cycle n+2+LAT. For n=32, LAT=2: cycle 36.
- Each cycle of `hold` in ISSUE adds one cycle.

Test Plan:
- len=32, no hold, model multiplier LAT=2 with no flags -> `rd_addr` 0..31 in cycles 1..32, `wr_addr` 0..31, `done` pulse at cycle 36, `full`=1, `flag_cnt`=0, `busy` low after `done`.
- len=5, `hold` high for 3 cycles after the 2nd issue -> exactly 5 reads (0..4) and no `rd_en` during hold, `done` at cycle 12, `wr_addr` 0..4.
- len=8, `mul_flag` on elements 2 and 7 -> `flag_or`=1, `flag_cnt`=2; next start clears both and `full`.
- len=0 -> 32 elements issued; len=40 -> clamps to 32; `start` pulsed during ISSUE -> ignored, issue count unchanged.
- Reset asserted mid-ISSUE at element 10 -> all outputs 0 immediately; a late `mul_valid_out` -> no `wr_en`, `err_spurious`=1; a new start then completes normally.
- Model drops the last result with len=4 -> `err_timeout`=1 after LAT+TMO=6 DRAIN cycles, `done` pulses, `full`=1, `flag_cnt` reflects only the 3 received results.
